// File: rtl/rgb_pixel_streamer_if.sv
// Word-in / pixel-out stream bundle between the source, the streamer and the gray-scale core.
// The master side is the streamer: it consumes the packed words and drives the pixel stream.
interface rgb_pixel_streamer_if #(
    parameter int unsigned MAX_PIXEL_BITS = 15
);
    logic                      word_valid_i;
    logic [31:0]               word_i;
    logic                      word_ready_o;
    logic [MAX_PIXEL_BITS-1:0] px_rgb_o;
    logic                      px_valid_o;
    logic                      start_o;
    logic                      finish_o;

    modport master (
        input  word_valid_i, word_i,
        output word_ready_o, px_rgb_o, px_valid_o, start_o, finish_o
    );

    modport slave (
        output word_valid_i, word_i,
        input  word_ready_o, px_rgb_o, px_valid_o, start_o, finish_o
    );
endinterface

// File: rtl/rgb_pixel_streamer.sv
// Unpacks 32-bit words holding two RGB555 pixels into a one-pixel-per-cycle frame stream,
// framing it with start/finish pulses for the gray-scale core.
module rgb_pixel_streamer #(
    parameter int unsigned MAX_PIXEL_BITS = 15,
    parameter int unsigned CNT_BITS       = 16
) (
    input  logic                clk_i,
    input  logic                nreset_i,
    input  logic                go_i,
    input  logic [CNT_BITS-1:0] cfg_npix_i,
    rgb_pixel_streamer_if.master bus,
    output logic                busy_o,
    output logic                done_o
);
    typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_e;
    typedef enum logic [1:0] {BUF_EMPTY, BUF_A, BUF_B} half_e;

    state_e                    state_q, state_d;
    half_e                     half_q, half_d;
    logic [29:0]               buf_q, buf_d;
    logic [CNT_BITS-1:0]       rem_q, rem_d;
    logic [CNT_BITS-1:0]       words_q, words_d;
    logic [MAX_PIXEL_BITS-1:0] px_q, px_d;
    logic                      pxv_q, pxv_d;
    logic                      start_q, start_d;
    logic                      first_q, first_d;
    logic                      zdone_q, zdone_d;

    logic ready;
    logic xfer;
    logic emit;
    logic unused_word_bits;

    assign unused_word_bits = bus.word_i[31] ^ bus.word_i[15];

    // Ready looks only at registered state: free buffer, or the last pending half leaves now.
    assign ready = (state_q == STREAM) && (words_q != '0) &&
                   ((half_q == BUF_EMPTY) || (half_q == BUF_B));
    assign xfer  = ready && bus.word_valid_i;

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        buf_d   = buf_q;
        rem_d   = rem_q;
        words_d = words_q;
        px_d    = px_q;
        pxv_d   = 1'b0;
        start_d = 1'b0;
        first_d = first_q;
        zdone_d = 1'b0;
        emit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    if (cfg_npix_i != '0) begin
                        state_d = STREAM;
                        rem_d   = cfg_npix_i;
                        words_d = (cfg_npix_i >> 1) + CNT_BITS'(cfg_npix_i[0]);
                        half_d  = BUF_EMPTY;
                        first_d = 1'b1;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                // The final pixel is on the output this cycle; finish follows it.
                if (rem_q == '0) begin
                    state_d = FINISH;
                end else begin
                    case (half_q)
                        BUF_A: begin
                            emit   = 1'b1;
                            px_d   = MAX_PIXEL_BITS'(buf_q[14:0]);
                            half_d = (rem_q == CNT_BITS'(1)) ? BUF_EMPTY : BUF_B;
                        end
                        BUF_B: begin
                            emit   = 1'b1;
                            px_d   = MAX_PIXEL_BITS'(buf_q[29:15]);
                            half_d = BUF_EMPTY;
                        end
                        default: ;
                    endcase
                    if (emit) begin
                        pxv_d   = 1'b1;
                        start_d = first_q;
                        first_d = 1'b0;
                        rem_d   = rem_q - CNT_BITS'(1);
                    end
                    if (xfer) begin
                        buf_d   = {bus.word_i[30:16], bus.word_i[14:0]};
                        half_d  = BUF_A;
                        words_d = words_q - CNT_BITS'(1);
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= IDLE;
            half_q  <= BUF_EMPTY;
            buf_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            px_q    <= '0;
            pxv_q   <= 1'b0;
            start_q <= 1'b0;
            first_q <= 1'b0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            buf_q   <= buf_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            px_q    <= px_d;
            pxv_q   <= pxv_d;
            start_q <= start_d;
            first_q <= first_d;
            zdone_q <= zdone_d;
        end
    end

    assign bus.word_ready_o = ready;
    assign bus.px_rgb_o     = px_q;
    assign bus.px_valid_o   = pxv_q;
    assign bus.start_o      = start_q;
    assign bus.finish_o     = (state_q == FINISH);
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == FINISH) || zdone_q;
endmodule

// File: tb/tb_rgb_pixel_streamer.sv
// Self-checking bench for rgb_pixel_streamer: table vectors, hand-written corner sequences
// and random frames compared against a word-list unpacking model.
module tb_rgb_pixel_streamer;
    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        go = 1'b0;
    logic [15:0] npix_cfg = '0;
    logic        busy;
    logic        done;

    rgb_pixel_streamer_if #(.MAX_PIXEL_BITS(15)) bus();

    rgb_pixel_streamer #(.MAX_PIXEL_BITS(15), .CNT_BITS(16)) dut (
        .clk_i      (clk),
        .nreset_i   (nreset),
        .go_i       (go),
        .cfg_npix_i (npix_cfg),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        int          npix;
        logic [31:0] w0;
        logic [31:0] w1;
        int          mode;   // 0 valid always, 1 random valid, 2 three-cycle gap after first word
        int          again;  // cycle of a repeated go, -1 for none
        logic [14:0] e[4];
    } vec_t;

    logic [31:0] src_q[$];
    logic [31:0] sent_q[$];
    logic [14:0] got_px[$];
    int          px_cyc[$];
    int          start_cnt, start_cyc, finish_cnt, finish_cyc, done_cnt, done_cyc, xfers;
    bit          busy_ok, hold_ok, finished;

    task automatic run_frame(input int n, input int mode, input int again_cyc);
        int   gap;
        bit   xfer, ven;
        logic [14:0] last_px;
        got_px.delete(); px_cyc.delete();
        start_cnt = 0; start_cyc = -1; finish_cnt = 0; finish_cyc = -1;
        done_cnt = 0; done_cyc = -1; xfers = 0; busy_ok = 1; hold_ok = 1;
        finished = 0; gap = 0; last_px = '0;
        sent_q = src_q;
        for (int c = 0; c < 400; c++) begin
            go = (c == 0) || (c == again_cyc);
            npix_cfg = (c == 0) ? 16'(n) : 16'(n + 5);
            ven = 1'b1;
            if (mode == 1) ven = ($urandom_range(0, 3) != 0);
            if (gap > 0) begin ven = 1'b0; gap--; end
            bus.word_valid_i = (src_q.size() > 0) && ven;
            bus.word_i = (src_q.size() > 0) ? src_q[0] : '0;
            @(negedge clk);
            xfer = bus.word_valid_i && bus.word_ready_o;
            if (bus.px_valid_o) begin
                got_px.push_back(bus.px_rgb_o);
                px_cyc.push_back(c);
                last_px = bus.px_rgb_o;
            end else if (got_px.size() > 0 && bus.px_rgb_o !== last_px) begin
                hold_ok = 0;
            end
            if (bus.start_o) begin start_cnt++; start_cyc = c; end
            if (bus.finish_o) begin finish_cnt++; if (finish_cyc < 0) finish_cyc = c; end
            if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
            if (busy !== ((c >= 1) && (finish_cyc < 0 || c <= finish_cyc))) busy_ok = 0;
            if (xfer) begin
                xfers++;
                if (mode == 2 && xfers == 1) gap = 3;
            end
            @(posedge clk); #1;
            if (xfer) void'(src_q.pop_front());
            if (finish_cyc >= 0 && c == finish_cyc + 2) begin finished = 1; break; end
        end
        go = 1'b0;
        bus.word_valid_i = 1'b0;
    endtask

    // Model: pixel i is the low or high 15-bit field of word i/2.
    task automatic verify(input string tag, input int n);
        logic [31:0] w;
        logic [14:0] e;
        int bad = 0;
        int last_cyc;
        check({tag, " completed"}, 32'(finished), 32'd1);
        for (int i = 0; i < n; i++) begin
            w = sent_q[i / 2];
            e = (i % 2 == 1) ? w[30:16] : w[14:0];
            if (i >= got_px.size() || got_px[i] !== e) bad++;
        end
        check({tag, " px count"}, 32'(got_px.size()), 32'(n));
        check({tag, " px data errors"}, 32'(bad), 32'd0);
        check({tag, " start count"}, 32'(start_cnt), 32'd1);
        check({tag, " start cycle"}, 32'(start_cyc), (px_cyc.size() > 0) ? 32'(px_cyc[0]) : 32'hFFFF_FFFE);
        last_cyc = (px_cyc.size() > 0) ? px_cyc[px_cyc.size() - 1] : -10;
        check({tag, " finish cycle"}, 32'(finish_cyc), 32'(last_cyc + 1));
        check({tag, " finish count"}, 32'(finish_cnt), 32'd1);
        check({tag, " done cycle"}, 32'(done_cyc), 32'(finish_cyc));
        check({tag, " transfers"}, 32'(xfers), 32'((n + 1) / 2));
        check({tag, " busy window"}, 32'(busy_ok), 32'd1);
        check({tag, " px hold"}, 32'(hold_ok), 32'd1);
    endtask

    vec_t tbl[4];
    int   n2;

    initial begin
        tbl[0] = '{4, 32'h7C00_03E0, 32'h001F_7FFF, 0, -1, '{15'h03E0, 15'h7C00, 15'h7FFF, 15'h001F}};
        tbl[1] = '{3, 32'h0001_0002, 32'h0003_0004, 0, -1, '{15'h0002, 15'h0001, 15'h0004, 15'h0000}};
        tbl[2] = '{4, 32'h7C00_03E0, 32'h001F_7FFF, 2, -1, '{15'h03E0, 15'h7C00, 15'h7FFF, 15'h001F}};
        tbl[3] = '{4, 32'h0001_0002, 32'h8003_8004, 0, 3, '{15'h0002, 15'h0001, 15'h0004, 15'h0003}};

        bus.word_valid_i = 1'b0;
        bus.word_i = '0;
        #1 nreset = 1'b0;
        #2;
        check("reset outputs", 32'({bus.px_rgb_o, bus.px_valid_o, bus.start_o, bus.finish_o,
                                    busy, done, bus.word_ready_o}), 32'd0);
        #20 nreset = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            src_q.delete();
            src_q.push_back(tbl[t].w0);
            src_q.push_back(tbl[t].w1);
            src_q.push_back(32'h7FFF_7FFF);
            run_frame(tbl[t].npix, tbl[t].mode, tbl[t].again);
            verify($sformatf("vec%0d", t), tbl[t].npix);
            for (int i = 0; i < tbl[t].npix; i++)
                check($sformatf("vec%0d px%0d", t, i),
                      (i < got_px.size()) ? 32'(got_px[i]) : 32'hDEAD, 32'(tbl[t].e[i]));
        end

        // Zero-length frame: only a done pulse.
        go = 1'b1; npix_cfg = '0; bus.word_valid_i = 1'b1; bus.word_i = 32'h1234_5678;
        @(negedge clk);
        check("npix0 go cycle", 32'({busy, done, bus.word_ready_o}), 32'd0);
        @(posedge clk); #1 go = 1'b0;
        @(negedge clk);
        check("npix0 done", 32'({done, busy, bus.start_o, bus.finish_o, bus.word_ready_o}), 32'b10000);
        @(negedge clk);
        check("npix0 after", 32'({done, busy, bus.word_ready_o}), 32'd0);
        bus.word_valid_i = 1'b0;
        @(posedge clk); #1;

        // Reset after two pixels of an 8-pixel frame.
        src_q.delete();
        for (int i = 0; i < 5; i++) src_q.push_back($urandom);
        go = 1'b1; npix_cfg = 16'd8;
        n2 = 0;
        for (int c = 0; c < 40 && n2 < 2; c++) begin
            bus.word_valid_i = 1'b1; bus.word_i = src_q[0];
            @(negedge clk);
            if (bus.px_valid_o) n2++;
            if (bus.word_ready_o) void'(src_q.pop_front());
            @(posedge clk); #1 go = 1'b0;
        end
        check("reset test px seen", 32'(n2), 32'd2);
        #2 nreset = 1'b0;
        #1;
        check("mid-frame reset outputs", 32'({bus.px_rgb_o, bus.px_valid_o, bus.start_o, bus.finish_o,
                                              busy, done, bus.word_ready_o}), 32'd0);
        bus.word_valid_i = 1'b0;
        @(negedge clk); #1 nreset = 1'b1;
        n2 = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.finish_o || busy || bus.px_valid_o) n2++;
        end
        check("after reset idle", 32'(n2), 32'd0);
        @(posedge clk); #1;
        src_q.delete();
        src_q.push_back(32'h2AAA_5555);
        src_q.push_back(32'h1111_2222);
        run_frame(2, 0, -1);
        verify("post-reset", 2);

        // Random frames with random source stalls and occasional repeated go.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 9);
            src_q.delete();
            for (int i = 0; i < (n + 1) / 2 + 2; i++) src_q.push_back($urandom);
            run_frame(n, 1, ($urandom_range(0, 1) == 1) ? 3 : -1);
            verify($sformatf("rand%0d", r), n);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
